// File: rtl/axi_write_data_slave_if.sv
// W and B channel bundle between the write-data master and the write-data slave.
interface axi_write_data_slave_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [3:0]            BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_write_data_slave.sv
// AXI write-data responder: buffers one burst of W beats into a FIFO toward a local
// sink, checks ID and WLAST framing against the latched descriptor, then returns one B.
module axi_write_data_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [3:0]                exp_id,
    input  logic [7:0]                exp_len,
    output logic                      busy,
    axi_write_data_slave_if.slave     w_if,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [DATA_WIDTH/8-1:0]   out_strb,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                current_state_out
);
    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + STRB_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_RECEIVE = 3'b001,
        S_DRAIN   = 3'b010,
        S_RESPOND = 3'b011
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           id_q, id_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [3:0]           bid_q, bid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 bvalid_q, bvalid_d;
    logic                 wready_q, wready_d;
    logic                 busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fcount_q, fcount_d;

    logic                 push;
    logic                 pop;
    logic                 final_beat;
    logic [ENTRY_W-1:0]   head;

    assign final_beat = (cnt_q == len_q);
    assign push       = (state_q == S_RECEIVE) && wready_q && w_if.WVALID;
    assign pop        = out_valid_q && out_ready;

    // Beat buffer; the final flag travels with each entry so out_last is slave-computed.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcount_d = fcount_q;
        if (push) begin
            mem_d[wr_ptr_q] = {w_if.WDATA, w_if.WSTRB, final_beat};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcount_d = fcount_q + CNT_W'(1);
            2'b01:   fcount_d = fcount_q - CNT_W'(1);
            default: fcount_d = fcount_q;
        endcase
    end

    // Burst control and response generation.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    id_d    = exp_id;
                    len_d   = exp_len;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (push) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((w_if.WID != id_q) || (w_if.WLAST != final_beat)) begin
                        err_d = 1'b1;
                    end
                    if (final_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fcount_d == CNT_W'(0)) begin
                    bid_d   = id_q;
                    bresp_d = err_q ? 2'b10 : 2'b00;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (bvalid_q && w_if.BREADY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from next-state values so they stay glitch-free.
    always_comb begin
        wready_d    = (state_d == S_RECEIVE) && (fcount_d != CNT_W'(FIFO_DEPTH));
        bvalid_d    = (state_d == S_RESPOND);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (fcount_d != CNT_W'(0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            id_q        <= 4'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            bid_q       <= 4'd0;
            bresp_q     <= 2'b00;
            bvalid_q    <= 1'b0;
            wready_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcount_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            bvalid_q    <= bvalid_d;
            wready_q    <= wready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcount_q    <= fcount_d;
            mem_q       <= mem_d;
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign out_data          = head[ENTRY_W-1 -: DATA_WIDTH];
    assign out_strb          = head[STRB_W:1];
    assign out_last          = head[0];
    assign out_valid         = out_valid_q;
    assign busy              = busy_q;
    assign current_state_out = state_q;
    assign w_if.WREADY       = wready_q;
    assign w_if.BVALID       = bvalid_q;
    assign w_if.BID          = bid_q;
    assign w_if.BRESP        = bresp_q;

endmodule

// File: doc/axi_write_data_slave.md
Name: axi_write_data_slave

Overview:
Responder end of the AXI write data channel plus its write-response channel. It accepts W beats for one burst, whose ID and length are latched at start. Beats are buffered in a small FIFO and forwarded to a local sink over a valid/ready stream. The block checks ID and WLAST framing, then issues a single B response per burst. It sits behind the slave-side address decoder, opposite the write-data master.

Parameters:
DATA_WIDTH, 32, W data width; multiple of 8, minimum 8
FIFO_DEPTH, 4, beat buffer depth; power of 2, minimum 2

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  reset, asynchronous, active-low
start  in  1  pulse: accept burst descriptor (honoured only in IDLE)
exp_id  in  4  expected WID for this burst, sampled on start
exp_len  in  8  AWLEN-style beats-1 (0..255), sampled on start
busy  out  1  high whenever state != IDLE
WID  in  4  write ID from master
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WLAST  in  1  master's last-beat flag
WVALID  in  1  master beat valid
WREADY  out  1  slave ready
out_data  out  DATA_WIDTH  FIFO head data
out_strb  out  DATA_WIDTH/8  FIFO head strobes
out_last  out  1  head is final beat of burst (slave-computed)
out_valid  out  1  FIFO not empty
out_ready  in  1  sink accepts head
BID  out  4  response ID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  master accepts response
current_state_out  out  3  IDLE 000, RECEIVE 001, DRAIN 010, RESPOND 011

Behaviour:
- Reset (async, resetn=0): state IDLE; FIFO emptied; beat counter 0; error flag 0; latched id/len 0. Outputs: WREADY=0, out_valid=0, BVALID=0, BID=0, BRESP=00, busy=0, current_state_out=000.
- IDLE: start=1 latches exp_id and exp_len, clears the counter and error flag, and moves to RECEIVE on the next edge. WREADY=0 in IDLE.
- RECEIVE: WREADY = !fifo_full. WREADY is a function of state and the FIFO count only; it never depends on WVALID.
- A beat is accepted when WVALID and WREADY are both high. On accept:
  - push {WDATA, WSTRB, final} into the FIFO, where final = (count == latched_len);
  - increment count.
- Error flag is set, sticky until the next start, when any of these holds on an accepted beat:
  - WID != latched id;
  - WLAST=1 and final=0;
  - WLAST=0 and final=1.
- Accepting the final beat moves to DRAIN. The burst is framed by exp_len, not by WLAST: beats after an early WLAST are still accepted and counted.
- DRAIN: WREADY=0. Move to RESPOND on the first cycle the FIFO is empty, evaluated after that cycle's pop.
- RESPOND: BVALID=1, BID=latched id, BRESP = error ? 10 : 00. BID and BRESP stay stable while BVALID is high. BVALID and BREADY both high moves to IDLE; BVALID is 0 in the next cycle.
- start is ignored outside IDLE. A start in the same cycle as the RESPOND handshake is also ignored.
- FIFO:
  - registered storage; a beat pushed at edge N is visible at out_valid/out_data after edge N, i.e. 1 cycle of latency;
  - pop when out_valid and out_ready are both high;
  - simultaneous push and pop leaves the occupancy unchanged; allowed when not full, or when not empty;
  - no pass-through when full: WREADY stays low in any cycle where the FIFO is full, even if a pop occurs that cycle;
  - read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; occupancy counter runs 0..FIFO_DEPTH.
- exp_len=0 gives a single-beat burst; that beat must carry WLAST=1.
- exp_len=255 gives 256 beats. The counter is 8 bits; it wraps to 0 after the final beat, which is harmless because start clears it.
- Downstream out_last comes only from the slave-computed final flag. It is asserted exactly once per burst.

Test Plan:
- start exp_id=5 exp_len=3; 4 beats with WVALID=1, out_ready=1, WLAST on beat 4 -> 4 out beats, out_last only on the 4th, each 1 cycle after its W beat; then BVALID with BID=5, BRESP=00; BREADY=1 -> IDLE, busy=0.
- out_ready=0, len=7 -> WREADY drops after 4 beats are accepted (FIFO full); out_ready=1 for 10 cycles -> all 8 beats arrive in order with no loss or duplication; B asserted only after the FIFO is empty.
- len=3, WLAST=1 on beat 2 -> still 4 beats accepted; out_last on beat 4 only; BRESP=10.
- exp_id=2, WID=3 on beat 1 of len=1 -> BRESP=10, BID=2.
- Hold BREADY=0 for 5 cycles in RESPOND and pulse start -> BVALID, BID and BRESP stable, state stays 011, start ignored; BREADY=1 -> 000.
- resetn=0 mid-RECEIVE after 2 of 4 beats -> immediately WREADY=0, out_valid=0, BVALID=0, state 000; a new start then runs a clean burst with BRESP=00.
